life_frame_streamer: RTL and testbench

Downstream companion of the 16×16 toroidal Life grid.
- Snapshots the 256-bit board state each time a new generation is produced.
- Streams the snapshot out as 16 rows of 16 bits over a valid/ready interface to a display or host link.
- Tracks generation count, population and still-life detection.
- Decouples the one-generation-per-cycle grid from a slower, back-pressuring consumer.

---
 rtl/life_frame_streamer_if.sv | 24 ++
 rtl/life_frame_streamer.sv | 102 ++++++++++
 tb/tb_life_frame_streamer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_frame_streamer_if.sv
// Row stream carrying one 16-bit board row per valid/ready handshake.
interface life_frame_streamer_if;
  logic [15:0] row_data;
  logic [3:0]  row_idx;
  logic        row_valid;
  logic        row_ready;
  logic        row_last;

  modport master (
    output row_data,
    output row_idx,
    output row_valid,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_idx,
    input  row_valid,
    input  row_last,
    output row_ready
  );
endinterface

// File: rtl/life_frame_streamer.sv
// Snapshots each new Life generation and streams it out as 16 rows, tracking
// generation count, population and still-life detection.
module life_frame_streamer #(
  parameter int GEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [255:0]            q_in,
  input  logic                    gen_strobe,
  input  logic                    load_in,
  life_frame_streamer_if.master   rows,
  output logic [GEN_W-1:0]        gen_count,
  output logic [8:0]              pop_count,
  output logic                    stable,
  output logic                    frame_drop
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]       state_reg;
  logic [255:0]     snap_reg;
  logic             prev_valid_reg;
  logic [3:0]       row_idx_reg;
  logic [GEN_W-1:0] gen_count_reg;
  logic [8:0]       pop_count_reg;
  logic             stable_reg;
  logic             frame_drop_reg;

  logic strobe_ok;
  logic handshake;
  logic final_hs;
  logic capture;

  function automatic logic [8:0] popcount256(input logic [255:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < 256; i++) begin
      c = c + 9'(v[i]);
    end
    return c;
  endfunction

  assign rows.row_valid = (state_reg == ST_SEND);
  assign rows.row_idx   = row_idx_reg;
  assign rows.row_data  = snap_reg[{row_idx_reg, 4'b0000} +: 16];
  assign rows.row_last  = rows.row_valid & (row_idx_reg == 4'd15);

  assign strobe_ok = gen_strobe & ~load_in;
  assign handshake = rows.row_valid & rows.row_ready;
  assign final_hs  = handshake & rows.row_last;
  // A strobe landing on the last-row handshake chains straight into a new frame.
  assign capture   = strobe_ok & ((state_reg == ST_IDLE) | final_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      snap_reg       <= '0;
      prev_valid_reg <= 1'b0;
      row_idx_reg    <= '0;
      gen_count_reg  <= '0;
      pop_count_reg  <= '0;
      stable_reg     <= 1'b0;
      frame_drop_reg <= 1'b0;
    end else begin
      frame_drop_reg <= strobe_ok & ~capture;

      if (load_in) begin
        gen_count_reg <= '0;
      end else if (strobe_ok) begin
        gen_count_reg <= gen_count_reg + GEN_W'(1);
      end

      if (capture) begin
        // The outgoing snapshot is the "previous" one the new board compares to.
        snap_reg       <= q_in;
        stable_reg     <= prev_valid_reg & (q_in == snap_reg);
        prev_valid_reg <= 1'b1;
        pop_count_reg  <= popcount256(q_in);
        row_idx_reg    <= '0;
        state_reg      <= ST_SEND;
      end else begin
        if (load_in) begin
          stable_reg     <= 1'b0;
          prev_valid_reg <= 1'b0;
        end
        if (handshake) begin
          row_idx_reg <= row_idx_reg + 4'd1;
          if (row_idx_reg == 4'd15) begin
            state_reg <= ST_IDLE;
          end
        end
      end
    end
  end

  assign gen_count  = gen_count_reg;
  assign pop_count  = pop_count_reg;
  assign stable     = stable_reg;
  assign frame_drop = frame_drop_reg;

endmodule

// File: tb/tb_life_frame_streamer.sv
// Directed bench for life_frame_streamer: each task drives one scenario and
// checks its outputs against hand-computed values.
module tb_life_frame_streamer;
  logic         clk;
  logic         rst_n;
  logic [255:0] q_in;
  logic         gen_strobe;
  logic         load_in;
  logic [15:0]  gen_count;
  logic [8:0]   pop_count;
  logic         stable;
  logic         frame_drop;

  int errors = 0;
  int checks = 0;

  life_frame_streamer_if row_if ();

  life_frame_streamer #(.GEN_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_in       (q_in),
    .gen_strobe (gen_strobe),
    .load_in    (load_in),
    .rows       (row_if),
    .gen_count  (gen_count),
    .pop_count  (pop_count),
    .stable     (stable),
    .frame_drop (frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture_once();
    gen_strobe = 1'b1;
    step();
    gen_strobe = 1'b0;
  endtask

  task automatic drain(input int n);
    row_if.row_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    q_in = '0;
    gen_strobe = 1'b0;
    load_in = 1'b0;
    row_if.row_ready = 1'b0;
    step();
    step();
    checks++;
    if ({row_if.row_valid, row_if.row_idx, row_if.row_data, row_if.row_last} !== 22'h0) begin
      errors++;
      $display("FAIL reset_rows: got %0h expected 0",
               {row_if.row_valid, row_if.row_idx, row_if.row_data, row_if.row_last});
    end
    checks++;
    if ({gen_count, pop_count, stable, frame_drop} !== 27'h0) begin
      errors++;
      $display("FAIL reset_status: got %0h expected 0", {gen_count, pop_count, stable, frame_drop});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (row_if.row_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid: got %0b expected 0", row_if.row_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_glider();
    logic [15:0] exp_row;
    q_in = '0;
    q_in[18] = 1'b1;
    q_in[35] = 1'b1;
    q_in[49] = 1'b1;
    q_in[50] = 1'b1;
    q_in[51] = 1'b1;
    row_if.row_ready = 1'b1;
    load_in = 1'b1;
    step();
    load_in = 1'b0;
    capture_once();
    q_in = '0;
    checks++;
    if (gen_count !== 16'd1) begin
      errors++;
      $display("FAIL glider_gen_count: got %0d expected 1", gen_count);
    end
    checks++;
    if (pop_count !== 9'd5) begin
      errors++;
      $display("FAIL glider_pop: got %0d expected 5", pop_count);
    end
    checks++;
    if (stable !== 1'b0) begin
      errors++;
      $display("FAIL glider_stable: got %0b expected 0", stable);
    end
    for (int r = 0; r < 16; r++) begin
      exp_row = (r == 1) ? 16'h0004 : (r == 2) ? 16'h0008 : (r == 3) ? 16'h000E : 16'h0000;
      checks++;
      if (row_if.row_valid !== 1'b1 || row_if.row_idx !== 4'(r) ||
          row_if.row_data !== exp_row || row_if.row_last !== (r == 15)) begin
        errors++;
        $display("FAIL glider_row%0d: got v=%0b idx=%0d data=%h last=%0b expected v=1 idx=%0d data=%h last=%0b",
                 r, row_if.row_valid, row_if.row_idx, row_if.row_data, row_if.row_last,
                 r, exp_row, (r == 15));
      end
      step();
    end
    checks++;
    if (row_if.row_valid !== 1'b0) begin
      errors++;
      $display("FAIL glider_end_valid: got %0b expected 0", row_if.row_valid);
    end
    $display("test_glider done");
  endtask

  task automatic test_block_stable();
    q_in = '0;
    q_in[85] = 1'b1;
    q_in[86] = 1'b1;
    q_in[101] = 1'b1;
    q_in[102] = 1'b1;
    capture_once();
    checks++;
    if (stable !== 1'b0 || pop_count !== 9'd4) begin
      errors++;
      $display("FAIL block_first: got stable=%0b pop=%0d expected stable=0 pop=4", stable, pop_count);
    end
    drain(16);
    capture_once();
    checks++;
    if (stable !== 1'b1 || pop_count !== 9'd4 || gen_count !== 16'd3) begin
      errors++;
      $display("FAIL block_second: got stable=%0b pop=%0d gen=%0d expected stable=1 pop=4 gen=3",
               stable, pop_count, gen_count);
    end
    drain(5);
    checks++;
    if (row_if.row_data !== 16'h0060 || row_if.row_idx !== 4'd5) begin
      errors++;
      $display("FAIL block_row5: got idx=%0d data=%h expected idx=5 data=0060",
               row_if.row_idx, row_if.row_data);
    end
    drain(11);
    $display("test_block_stable done");
  endtask

  task automatic test_backpressure();
    logic [7:0]  lfsr;
    logic [15:0] prev_data;
    logic [3:0]  prev_idx;
    logic        prev_stalled;
    int          next_row;
    for (int r = 0; r < 16; r++) q_in[r*16 +: 16] = 16'hA500 | 16'(r);
    row_if.row_ready = 1'b0;
    capture_once();
    lfsr = 8'h5A;
    prev_stalled = 1'b0;
    prev_data = '0;
    prev_idx = '0;
    next_row = 0;
    for (int cyc = 0; cyc < 300 && next_row < 16; cyc++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      row_if.row_ready = lfsr[0];
      checks++;
      if (row_if.row_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_valid: got %0b expected 1 at cycle %0d", row_if.row_valid, cyc);
      end
      if (prev_stalled) begin
        checks++;
        if (row_if.row_data !== prev_data || row_if.row_idx !== prev_idx) begin
          errors++;
          $display("FAIL bp_hold: got idx=%0d data=%h expected idx=%0d data=%h",
                   row_if.row_idx, row_if.row_data, prev_idx, prev_data);
        end
      end
      if (row_if.row_ready) begin
        checks++;
        if (row_if.row_idx !== 4'(next_row) || row_if.row_data !== (16'hA500 | 16'(next_row))) begin
          errors++;
          $display("FAIL bp_row: got idx=%0d data=%h expected idx=%0d data=%h",
                   row_if.row_idx, row_if.row_data, next_row, 16'hA500 | 16'(next_row));
        end
        next_row++;
      end
      prev_stalled = ~row_if.row_ready;
      prev_data = row_if.row_data;
      prev_idx = row_if.row_idx;
      step();
    end
    checks++;
    if (next_row != 16 || row_if.row_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete: got rows=%0d valid=%0b expected rows=16 valid=0",
               next_row, row_if.row_valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_back_to_back();
    logic [15:0] val;
    logic [15:0] exp_data;
    row_if.row_ready = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      val = 16'h1000 + 16'(k);
      q_in = {16{val}};
      gen_strobe = 1'b1;
      step();
      exp_data = 16'h1000 + 16'((k / 16) * 16);
      checks++;
      if (row_if.row_valid !== 1'b1 || frame_drop !== ((k % 16) != 0) ||
          row_if.row_idx !== 4'(k % 16) || gen_count !== 16'(5 + k) ||
          row_if.row_data !== exp_data) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%0b drop=%0b idx=%0d gen=%0d data=%h expected v=1 drop=%0b idx=%0d gen=%0d data=%h",
                 k, row_if.row_valid, frame_drop, row_if.row_idx, gen_count, row_if.row_data,
                 ((k % 16) != 0), k % 16, 5 + k, exp_data);
      end
    end
    gen_strobe = 1'b0;
    step();
    checks++;
    if (frame_drop !== 1'b0 || row_if.row_idx !== 4'd1 || gen_count !== 16'd37) begin
      errors++;
      $display("FAIL b2b_tail: got drop=%0b idx=%0d gen=%0d expected drop=0 idx=1 gen=37",
               frame_drop, row_if.row_idx, gen_count);
    end
    drain(15);
    checks++;
    if (row_if.row_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got %0b expected 0", row_if.row_valid);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_load_mid();
    q_in = {16{16'h1020}};
    capture_once();
    checks++;
    if (stable !== 1'b1 || pop_count !== 9'd32 || gen_count !== 16'd38) begin
      errors++;
      $display("FAIL load_pre: got stable=%0b pop=%0d gen=%0d expected stable=1 pop=32 gen=38",
               stable, pop_count, gen_count);
    end
    drain(3);
    q_in = '0;
    load_in = 1'b1;
    gen_strobe = 1'b1;
    step();
    load_in = 1'b0;
    gen_strobe = 1'b0;
    checks++;
    if (gen_count !== 16'd0 || stable !== 1'b0 || frame_drop !== 1'b0 || pop_count !== 9'd32) begin
      errors++;
      $display("FAIL load_status: got gen=%0d stable=%0b drop=%0b pop=%0d expected gen=0 stable=0 drop=0 pop=32",
               gen_count, stable, frame_drop, pop_count);
    end
    for (int r = 4; r < 16; r++) begin
      checks++;
      if (row_if.row_valid !== 1'b1 || row_if.row_idx !== 4'(r) || row_if.row_data !== 16'h1020) begin
        errors++;
        $display("FAIL load_row%0d: got v=%0b idx=%0d data=%h expected v=1 idx=%0d data=1020",
                 r, row_if.row_valid, row_if.row_idx, row_if.row_data, r);
      end
      step();
    end
    checks++;
    if (row_if.row_valid !== 1'b0 || gen_count !== 16'd0) begin
      errors++;
      $display("FAIL load_end: got v=%0b gen=%0d expected v=0 gen=0", row_if.row_valid, gen_count);
    end
    $display("test_load_mid done");
  endtask

  task automatic test_reset_mid();
    q_in = {256{1'b1}};
    capture_once();
    checks++;
    if (pop_count !== 9'd256 || gen_count !== 16'd1 || stable !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre: got pop=%0d gen=%0d stable=%0b expected pop=256 gen=1 stable=0",
               pop_count, gen_count, stable);
    end
    drain(7);
    checks++;
    if (row_if.row_idx !== 4'd7 || row_if.row_data !== 16'hFFFF) begin
      errors++;
      $display("FAIL rstmid_row7: got idx=%0d data=%h expected idx=7 data=ffff",
               row_if.row_idx, row_if.row_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({row_if.row_valid, row_if.row_idx, row_if.row_data, row_if.row_last,
         gen_count, pop_count, stable, frame_drop} !== 49'h0) begin
      errors++;
      $display("FAIL rstmid_async: got %0h expected 0",
               {row_if.row_valid, row_if.row_idx, row_if.row_data, row_if.row_last,
                gen_count, pop_count, stable, frame_drop});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (row_if.row_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_idle%0d: got %0b expected 0", i, row_if.row_valid);
      end
    end
    capture_once();
    checks++;
    if (row_if.row_valid !== 1'b1 || row_if.row_idx !== 4'd0 || gen_count !== 16'd1 ||
        stable !== 1'b0 || pop_count !== 9'd256) begin
      errors++;
      $display("FAIL rstmid_recap: got v=%0b idx=%0d gen=%0d stable=%0b pop=%0d expected v=1 idx=0 gen=1 stable=0 pop=256",
               row_if.row_valid, row_if.row_idx, gen_count, stable, pop_count);
    end
    drain(16);
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_glider();
    test_block_stable();
    test_backpressure();
    test_back_to_back();
    test_load_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
